// File: rtl/relu_packer_if.sv
// Sample-in / packed-word-out handshake bundle for relu_packer.
// Both streams use valid/ready: a transfer happens on a rising edge where valid && ready.
interface relu_packer_if #(
    parameter int DATA_W = 16,
    parameter int LANES  = 4
);
    localparam int LW = $clog2(LANES + 1);

    logic                    in_valid;
    logic                    in_ready;
    logic [DATA_W-1:0]       in_data;
    logic                    in_last;
    logic                    relu_en;
    logic                    out_valid;
    logic                    out_ready;
    logic [LANES*DATA_W-1:0] out_data;
    logic [LW-1:0]           out_lanes;
    logic                    out_last;

    // Source/sink side (accumulator upstream, plane RAM downstream).
    modport master (
        output in_valid, in_data, in_last, relu_en, out_ready,
        input  in_ready, out_valid, out_data, out_lanes, out_last
    );

    // Packer side.
    modport slave (
        input  in_valid, in_data, in_last, relu_en, out_ready,
        output in_ready, out_valid, out_data, out_lanes, out_last
    );
endinterface

// File: rtl/relu_packer.sv
// ReLU clamp plus MSB-lane-first packing of accumulator results into LANES-wide words,
// with a single back-pressured output register.
module relu_packer #(
    parameter int DATA_W = 16,
    parameter int LANES  = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    relu_packer_if.slave bus
);
    localparam int LW = $clog2(LANES + 1);
    localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int WW = LANES * DATA_W;

    logic [IW-1:0]     idx_q, idx_d;
    logic [DATA_W-1:0] lane_q [LANES];
    logic [DATA_W-1:0] lane_d [LANES];
    logic              out_valid_q, out_valid_d;
    logic [WW-1:0]     out_data_q, out_data_d;
    logic [LW-1:0]     out_lanes_q, out_lanes_d;
    logic              out_last_q, out_last_d;

    logic              in_ready;
    logic              accept;
    logic              close;
    logic [DATA_W-1:0] sample;
    logic [WW-1:0]     word;

    always_comb begin
        in_ready = !out_valid_q || bus.out_ready;
        accept   = bus.in_valid && in_ready;
        close    = accept && ((idx_q == IW'(LANES - 1)) || bus.in_last);
        sample   = (bus.relu_en && bus.in_data[DATA_W-1]) ? '0 : bus.in_data;

        // Lanes past the one being written are forced to zero regardless of pack contents.
        word = '0;
        for (int k = 0; k < LANES; k++) begin
            if (k < int'(idx_q)) begin
                word[(LANES-k)*DATA_W-1 -: DATA_W] = lane_q[k];
            end else if (k == int'(idx_q)) begin
                word[(LANES-k)*DATA_W-1 -: DATA_W] = sample;
            end
        end

        idx_d       = idx_q;
        lane_d      = lane_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_lanes_d = out_lanes_q;
        out_last_d  = out_last_q;

        if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        // A close in the same cycle as a consume reloads the register back-to-back.
        if (close) begin
            out_valid_d = 1'b1;
            out_data_d  = word;
            out_lanes_d = LW'(idx_q) + LW'(1);
            out_last_d  = bus.in_last;
            idx_d       = '0;
            for (int k = 0; k < LANES; k++) begin
                lane_d[k] = '0;
            end
        end else if (accept) begin
            lane_d[idx_q] = sample;
            idx_d         = idx_q + IW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_lanes_q <= '0;
            out_last_q  <= 1'b0;
            for (int k = 0; k < LANES; k++) begin
                lane_q[k] <= '0;
            end
        end else begin
            idx_q       <= idx_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_lanes_q <= out_lanes_d;
            out_last_q  <= out_last_d;
            for (int k = 0; k < LANES; k++) begin
                lane_q[k] <= lane_d[k];
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_lanes = out_lanes_q;
    assign bus.out_last  = out_last_q;
endmodule

// File: tb/tb_relu_packer.sv
// Directed bench for relu_packer: a 16x4 instance and an 8x8 instance, with an
// in-order scoreboard on every transferred output word.
module tb_relu_packer;
  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  logic [71:0] q4[$];
  logic [71:0] q8[$];

  relu_packer_if #(.DATA_W(16), .LANES(4)) b4 ();
  relu_packer_if #(.DATA_W(8),  .LANES(8)) b8 ();

  relu_packer #(.DATA_W(16), .LANES(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(b4.slave));
  relu_packer #(.DATA_W(8),  .LANES(8)) u8 (.clk(clk), .rst_n(rst_n), .bus(b8.slave));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [71:0] pk(input logic [63:0] d, input logic [3:0] l, input logic last);
    return {3'b000, d, l, last};
  endfunction

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // scoreboards: sample on negedge, a transfer happens at the following posedge
  always @(negedge clk) begin
    if (rst_n && b4.out_valid && b4.out_ready) begin
      if (q4.size() == 0) check("sb4_unexpected", pk(b4.out_data, 4'(b4.out_lanes), b4.out_last), 72'd0);
      else check("sb4_word", pk(b4.out_data, 4'(b4.out_lanes), b4.out_last), q4.pop_front());
    end
    if (rst_n && b8.out_valid && b8.out_ready) begin
      if (q8.size() == 0) check("sb8_unexpected", pk(b8.out_data, 4'(b8.out_lanes), b8.out_last), 72'd0);
      else check("sb8_word", pk(b8.out_data, 4'(b8.out_lanes), b8.out_last), q8.pop_front());
    end
  end

  // driver tasks: called at posedge+1, return at posedge+1 after the accepting edge
  task automatic send4(input logic [15:0] d, input logic last, input logic relu);
    logic ok;
    ok = 1'b0;
    b4.in_valid = 1'b1; b4.in_data = d; b4.in_last = last; b4.relu_en = relu;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (b4.in_ready) begin ok = 1'b1; break; end
    end
    check("accept4", 72'(ok), 72'd1);
    @(posedge clk); #1;
    b4.in_valid = 1'b0;
  endtask

  task automatic send8(input logic [7:0] d, input logic last);
    logic ok;
    ok = 1'b0;
    b8.in_valid = 1'b1; b8.in_data = d; b8.in_last = last; b8.relu_en = 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (b8.in_ready) begin ok = 1'b1; break; end
    end
    check("accept8", 72'(ok), 72'd1);
    @(posedge clk); #1;
    b8.in_valid = 1'b0;
  endtask

  initial begin
    int start;
    rst_n = 1'b0;
    b4.in_valid = 1'b0; b4.in_data = '0; b4.in_last = 1'b0; b4.relu_en = 1'b0; b4.out_ready = 1'b1;
    b8.in_valid = 1'b0; b8.in_data = '0; b8.in_last = 1'b0; b8.relu_en = 1'b0; b8.out_ready = 1'b1;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_out_valid", 72'(b4.out_valid), 72'd0);
    check("rst_out_data",  72'(b4.out_data),  72'd0);
    check("rst_out_lanes", 72'(b4.out_lanes), 72'd0);
    check("rst_out_last",  72'(b4.out_last),  72'd0);
    check("rst_in_ready",  72'(b4.in_ready),  72'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // ReLU enabled: negative lane clamps to zero
    q4.push_back(pk(64'h0001_0002_0000_0004, 4'd4, 1'b0));
    send4(16'h0001, 0, 1); send4(16'h0002, 0, 1); send4(16'h8003, 0, 1); send4(16'h0004, 0, 1);
    @(negedge clk);
    check("relu_on_valid", 72'(b4.out_valid), 72'd1);
    check("relu_on_data",  72'(b4.out_data),  72'h0001_0002_0000_0004);
    check("relu_on_lanes", 72'(b4.out_lanes), 72'd4);
    check("relu_on_last",  72'(b4.out_last),  72'd0);
    @(negedge clk);
    check("valid_one_cycle", 72'(b4.out_valid), 72'd0);
    @(posedge clk); #1;

    // ReLU disabled: value passes unchanged
    q4.push_back(pk(64'h0001_0002_8003_0004, 4'd4, 1'b0));
    send4(16'h0001, 0, 0); send4(16'h0002, 0, 0); send4(16'h8003, 0, 0); send4(16'h0004, 0, 0);
    @(negedge clk);
    check("relu_off_data", 72'(b4.out_data), 72'h0001_0002_8003_0004);
    @(posedge clk); #1;

    // plane-terminated partial word, then a full word
    q4.push_back(pk(64'h1111_2222_0000_0000, 4'd2, 1'b1));
    send4(16'h1111, 0, 1); send4(16'h2222, 1, 1);
    @(negedge clk);
    check("partial_data",  72'(b4.out_data),  72'h1111_2222_0000_0000);
    check("partial_lanes", 72'(b4.out_lanes), 72'd2);
    check("partial_last",  72'(b4.out_last),  72'd1);
    @(posedge clk); #1;
    q4.push_back(pk(64'h3333_3333_3333_3333, 4'd4, 1'b0));
    for (int i = 0; i < 4; i++) send4(16'h3333, 0, 1);
    @(negedge clk);
    check("full_lanes", 72'(b4.out_lanes), 72'd4);
    @(posedge clk); #1;

    // in_last on lane 3 and on the very first sample (back-to-back single-lane words)
    q4.push_back(pk(64'h0011_0022_0033_0044, 4'd4, 1'b1));
    q4.push_back(pk(64'h0042_0000_0000_0000, 4'd1, 1'b1));
    q4.push_back(pk(64'h0043_0000_0000_0000, 4'd1, 1'b1));
    send4(16'h0011, 0, 1); send4(16'h0022, 0, 1); send4(16'h0033, 0, 1); send4(16'h0044, 1, 1);
    send4(16'h0042, 1, 1);
    send4(16'h0043, 1, 1);
    @(negedge clk);
    check("single_lanes", 72'(b4.out_lanes), 72'd1);
    @(posedge clk); #1;

    // backpressure: word held, input stalled, nothing lost on release
    b4.out_ready = 1'b0;
    q4.push_back(pk(64'h0005_0006_0007_0008, 4'd4, 1'b0));
    q4.push_back(pk(64'h0009_000A_000B_000C, 4'd4, 1'b0));
    send4(16'h0005, 0, 1); send4(16'h0006, 0, 1); send4(16'h0007, 0, 1); send4(16'h0008, 0, 1);
    b4.in_valid = 1'b1; b4.in_data = 16'h0009; b4.in_last = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_in_ready", 72'(b4.in_ready),  72'd0);
      check("stall_valid",    72'(b4.out_valid), 72'd1);
      check("stall_hold",     72'(b4.out_data),  72'h0005_0006_0007_0008);
    end
    @(posedge clk); #1;
    b4.out_ready = 1'b1;
    send4(16'h0009, 0, 1); send4(16'h000A, 0, 1); send4(16'h000B, 0, 1); send4(16'h000C, 0, 1);
    @(negedge clk);
    check("release_data", 72'(b4.out_data), 72'h0009_000A_000B_000C);
    @(posedge clk); #1;

    // reset discards an unconsumed output word
    b4.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send4(16'h0F0F, 0, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_drop_valid", 72'(b4.out_valid), 72'd0);
    check("rst_drop_data",  72'(b4.out_data),  72'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    b4.out_ready = 1'b1;

    // reset mid-word discards the partial word
    send4(16'hAAAA, 0, 1); send4(16'hBBBB, 0, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid_valid", 72'(b4.out_valid), 72'd0);
    check("rst_mid_ready", 72'(b4.in_ready),  72'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    q4.push_back(pk(64'h0001_0002_0003_0004, 4'd4, 1'b0));
    send4(16'h0001, 0, 1); send4(16'h0002, 0, 1); send4(16'h0003, 0, 1); send4(16'h0004, 0, 1);
    @(negedge clk);
    check("rst_mid_data", 72'(b4.out_data), 72'h0001_0002_0003_0004);
    @(posedge clk); #1;

    // 8x8 instance: 16 back-to-back samples, two words, no bubbles
    q8.push_back(pk(64'h0102030405060708, 4'd8, 1'b0));
    q8.push_back(pk(64'h090A0B0C0D0E0F10, 4'd8, 1'b0));
    start = cyc;
    for (int i = 1; i <= 16; i++) send8(8'(i), 0);
    check("lanes8_cycles", 72'(cyc - start), 72'd16);
    @(negedge clk);
    check("lanes8_data", 72'(b8.out_data), 72'h090A0B0C0D0E0F10);

    repeat (4) @(negedge clk);
    check("q4_drained", 72'(q4.size()), 72'd0);
    check("q8_drained", 72'(q8.size()), 72'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
